i2c_master_ctrl: RTL and testbench

//  Single-byte I2C bus master that sequences transactions to downstream I2C slaves (e.g. addr 7'd48).

---
 rtl/i2c_master_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C bus master.
// One command per valid/ready handshake: START, {addr,rw}, one data byte
// (written, or read and master-NACKed), STOP. Pads are open-drain: *_oe=1
// pulls the line low, *_oe=0 lets the external pull-up raise it.
//
// Handshake: a command is accepted on a clk edge where cmd_valid && cmd_ready;
// cmd_ready is high exactly while the controller is idle, and cmd_valid is
// ignored otherwise. rsp_valid is a one-cycle pulse that comes with no ready
// (the response cannot be back-pressured); rsp_rdata/rsp_nack stay stable until
// the next accept.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WDATA,
    S_WACK,
    S_RDATA,
    S_MNACK,
    S_STOP
  } state_t;

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       phase;
  logic [2:0]       bit_cnt;
  logic [7:0]       addr_byte;
  logic [7:0]       wdata_q;
  logic             accept;
  logic             stall;
  logic             tick;
  logic             bit_done;
  logic             shift_state;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign dbg_state = state;

  // A slave holding SCL low while we have released it freezes the bit timing.
  assign stall    = busy && ((phase == 2'd1) || (phase == 2'd2)) && !scl_oe && !scl_in;
  assign tick     = busy && !stall && (div_cnt == DIV_LAST);
  assign bit_done = tick && (phase == 2'd3);

  // States that move eight bits and use bit_cnt as the bit index.
  assign shift_state = (state == S_ADDR) || (state == S_WDATA) || (state == S_RDATA);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and pad drive, decoded from state, phase and bit index.
  always_comb begin
    state_next = state;
    scl_oe     = 1'b0;
    sda_oe     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_next = S_START;
      end
      S_START: begin
        // SDA falls in p1 while SCL is still high, then SCL goes low in p3.
        scl_oe = (phase == 2'd3);
        sda_oe = (phase != 2'd0);
        if (bit_done) state_next = S_ADDR;
      end
      S_ADDR: begin
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        sda_oe = ~addr_byte[bit_cnt];
        if (bit_done && (bit_cnt == 3'd0)) state_next = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        if (bit_done) begin
          if (rsp_nack)          state_next = S_STOP;
          else if (addr_byte[0]) state_next = S_RDATA;
          else                   state_next = S_WDATA;
        end
      end
      S_WDATA: begin
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        sda_oe = ~wdata_q[bit_cnt];
        if (bit_done && (bit_cnt == 3'd0)) state_next = S_WACK;
      end
      S_WACK: begin
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        if (bit_done) state_next = S_STOP;
      end
      S_RDATA: begin
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        if (bit_done && (bit_cnt == 3'd0)) state_next = S_MNACK;
      end
      S_MNACK: begin
        // SDA left released for one bit: the master NACK ending the read.
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        if (bit_done) state_next = S_STOP;
      end
      S_STOP: begin
        // SDA held low until SCL is high, then released in p3 (rising SDA).
        scl_oe = (phase == 2'd0);
        sda_oe = (phase != 2'd3);
        if (bit_done) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Quarter-period divider and bit phase; both idle at zero between commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase   <= 2'd0;
    end else if (accept) begin
      div_cnt <= '0;
      phase   <= 2'd0;
    end else if (busy && !stall) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        phase   <= phase + 2'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Bit index, counts 7 down to 0 inside each byte and wraps back to 7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd7;
    end else if (accept) begin
      bit_cnt <= 3'd7;
    end else if (bit_done && shift_state) begin
      bit_cnt <= bit_cnt - 3'd1;
    end
  end

  // Command capture at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_byte <= 8'h00;
      wdata_q   <= 8'h00;
    end else if (accept) begin
      addr_byte <= {cmd_addr, cmd_rw};
      wdata_q   <= cmd_wdata;
    end
  end

  // Response: SDA is sampled at the end of p2 (SCL high); result held until next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nack  <= 1'b0;
    end else begin
      rsp_valid <= (state == S_STOP) && bit_done;
      if (accept) begin
        rsp_rdata <= 8'h00;
        rsp_nack  <= 1'b0;
      end else if (tick && (phase == 2'd2)) begin
        if ((state == S_ADDR_ACK) && sda_in) rsp_nack  <= 1'b1;
        if (state == S_WACK)                 rsp_nack  <= sda_in;
        if (state == S_RDATA)                rsp_rdata <= {rsp_rdata[6:0], sda_in};
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Testbench for i2c_master_ctrl: open-drain bus with a behavioural slave at
// address 0x30, a bus monitor that rebuilds bytes and ACK bits between
// START and STOP, and randomized commands checked against a reference model.
module tb_i2c_master_ctrl;

  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT and bus ----------------
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = 7'h00;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic [3:0] dbg_state;
  logic       slv_scl_low = 1'b0;
  logic       slv_sda_low = 1'b0;
  logic       scl_bus;
  logic       sda_bus;

  assign scl_bus = !(scl_oe || slv_scl_low);
  assign sda_bus = !(sda_oe || slv_sda_low);

  i2c_master_ctrl #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_rw    (cmd_rw),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .scl_in    (scl_bus),
    .sda_in    (sda_bus),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [6:0] slv_addr = 7'h30;
  logic [7:0] slv_rbyte = 8'h00;
  logic       slv_dnack = 1'b0;
  int         stretch_rise = 0;
  int         stretch_len = 0;

  int         rise_n = 0;
  int         fall_n = 0;
  logic [7:0] rx_byte = 8'h00;

  // ---------------- bus monitor ----------------
  bit         in_txn = 1'b0;
  int         illegal = 0;
  int         partial_cnt = 0;
  logic       mon_bits[$];
  logic [8:0] obs_q[$];

  // START: SDA falls while SCL high.
  always @(negedge sda_bus) begin
    if (scl_bus === 1'b1) begin
      if (in_txn) illegal++;
      in_txn = 1'b1;
      mon_bits.delete();
      rise_n = 0;
      fall_n = -1;
    end
  end

  // STOP: SDA rises while SCL high; package collected bits as {byte, ack}.
  always @(posedge sda_bus) begin
    if (scl_bus === 1'b1) begin
      logic [8:0] w;
      if (!in_txn) illegal++;
      in_txn = 1'b0;
      if (mon_bits.size() > 0) void'(mon_bits.pop_back());  // SCL rise of the STOP itself
      while (mon_bits.size() >= 9) begin
        w = '0;
        for (int i = 0; i < 9; i++) w = {w[7:0], mon_bits.pop_front()};
        obs_q.push_back(w);
      end
      if (mon_bits.size() != 0) partial_cnt++;
      mon_bits.delete();
    end
  end

  // Data is taken on every SCL rise inside a transaction.
  always @(posedge scl_bus) begin
    if (in_txn) begin
      rise_n++;
      mon_bits.push_back(sda_bus);
      if (rise_n <= 8) rx_byte = {rx_byte[6:0], sda_bus};
    end
  end

  // Slave reacts just after each SCL fall: ACKs, read data, optional stretch.
  always @(negedge scl_bus) begin
    if (in_txn) begin
      bit low;
      bit match;
      fall_n++;
      #1;
      low   = 1'b0;
      match = (rx_byte[7:1] == slv_addr);
      if (fall_n == 8)                                        low = match;
      else if (match && rx_byte[0] && fall_n >= 9 && fall_n <= 16) low = !slv_rbyte[16 - fall_n];
      else if (match && !rx_byte[0] && fall_n == 17)         low = !slv_dnack;
      slv_sda_low = low;
      if (stretch_rise > 0 && fall_n == stretch_rise - 1) begin
        slv_scl_low = 1'b1;
        repeat (stretch_len) @(posedge clk);
        slv_scl_low = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic       nack;
    logic [7:0] rdata;
    int         lo;
    int         hi;
  } rsp_t;

  logic [8:0] exp_q[$];
  rsp_t       rsp_q[$];
  int         acc_cyc = 0;
  logic       last_nack = 1'b0;
  logic [7:0] last_rdata = 8'h00;
  logic [3:0] idle_code = 4'h0;

  task automatic stop_now(input string tag);
    check_eq(tag, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bounded wait expired");
  endtask

  // Reference model: expected bus words and response from the command and slave setup.
  task automatic start_cmd(input logic [6:0] addr, input logic rw, input logic [7:0] wdata,
                           input logic [7:0] rbyte, input logic dnack,
                           input int srise, input int slen);
    int   n = 0;
    bit   ack;
    rsp_t r;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) stop_now("ready_timeout");
    check_eq("rsp_nack_hold", rsp_nack, last_nack);
    check_eq("rsp_rdata_hold", rsp_rdata, last_rdata);
    slv_rbyte    = rbyte;
    slv_dnack    = dnack;
    stretch_rise = srise;
    stretch_len  = slen;
    ack = (addr == slv_addr);
    exp_q.push_back({addr, rw, !ack});
    if (ack) exp_q.push_back(rw ? {rbyte, 1'b1} : {wdata, dnack});
    r.nack  = !ack || (!rw && dnack);
    r.rdata = (ack && rw) ? rbyte : 8'h00;
    r.lo    = (ack ? 80 : 44) * D;
    r.hi    = r.lo + 2;
    if (slen > 0) begin
      r.lo = r.lo + slen - 2 * D - 1;
      r.hi = r.hi + slen;
    end
    rsp_q.push_back(r);
    cmd_addr  = addr;
    cmd_rw    = rw;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    check_eq("accept_busy", busy, 1);
    check_eq("accept_ready", cmd_ready, 0);
    check_eq("accept_nack_clr", rsp_nack, 0);
    check_eq("accept_no_rsp", rsp_valid, 0);
  endtask

  task automatic finish_cmd(input bit hold);
    int   n = 0;
    int   early_ready = 0;
    int   lat;
    rsp_t r;
    r = rsp_q.pop_front();
    if (!hold) cmd_valid = 1'b0;
    while (!rsp_valid && n < 3000) begin
      if (cmd_ready) early_ready++;
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) stop_now("rsp_timeout");
    lat = cyc - acc_cyc;
    check_eq($sformatf("latency=%0d window=%0d..%0d", lat, r.lo, r.hi),
             (lat >= r.lo) && (lat <= r.hi), 1);
    check_eq("rsp_nack", rsp_nack, r.nack);
    check_eq("rsp_rdata", rsp_rdata, r.rdata);
    check_eq("done_ready", cmd_ready, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_lines", {scl_oe, sda_oe}, 2'b00);
    check_eq("ready_while_busy", early_ready, 0);
    check_eq("dbg_idle", dbg_state, idle_code);
    check_eq("partial_bits", partial_cnt, 0);
    while (exp_q.size() > 0) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      if (obs_q.size() == 0) check_eq("bus_missing", 9'h000, e);
      else                   check_eq("bus_word", obs_q.pop_front(), e);
    end
    check_eq("bus_extra", obs_q.size(), 0);
    last_nack  = r.nack;
    last_rdata = r.rdata;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_scl_oe", scl_oe, 0);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rdata", rsp_rdata, 0);
    check_eq("rst_nack", rsp_nack, 0);
    idle_code = dbg_state;
    rst_n = 1'b1;
    @(negedge clk);
    in_txn = 1'b0;
    illegal = 0;
    mon_bits.delete();
    obs_q.delete();

    // Plain write, plain read, absent slave.
    start_cmd(7'h30, 1'b0, 8'hA5, 8'h00, 1'b0, 0, 0);
    finish_cmd(1'b0);
    start_cmd(7'h30, 1'b1, 8'h00, 8'h0C, 1'b0, 0, 0);
    finish_cmd(1'b0);
    start_cmd(7'h31, 1'b0, 8'h77, 8'h00, 1'b0, 0, 0);
    finish_cmd(1'b0);

    // Slave stretches SCL during write data bit 3 (SCL rise 14).
    start_cmd(7'h30, 1'b0, 8'h96, 8'h00, 1'b0, 14, 50);
    finish_cmd(1'b0);

    // Reset in the middle of the write data byte, then a normal write.
    start_cmd(7'h30, 1'b0, 8'h5A, 8'h00, 1'b0, 0, 0);
    cmd_valid = 1'b0;
    repeat (50 * D) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_scl_oe", scl_oe, 0);
    check_eq("midrst_sda_oe", sda_oe, 0);
    check_eq("midrst_ready", cmd_ready, 1);
    check_eq("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    void'(rsp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
    mon_bits.delete();
    in_txn      = 1'b0;
    illegal     = 0;
    partial_cnt = 0;
    slv_sda_low = 1'b0;
    slv_scl_low = 1'b0;
    last_nack   = 1'b0;
    last_rdata  = 8'h00;
    @(negedge clk);
    start_cmd(7'h30, 1'b0, 8'hC3, 8'h00, 1'b0, 0, 0);
    finish_cmd(1'b0);

    // cmd_valid held across the response: next accept only after rsp_valid.
    start_cmd(7'h30, 1'b0, 8'h3C, 8'h00, 1'b0, 0, 0);
    finish_cmd(1'b1);
    start_cmd(7'h30, 1'b0, 8'h3C, 8'h00, 1'b0, 0, 0);
    finish_cmd(1'b0);

    // Randomized commands.
    for (int t = 0; t < 20; t++) begin
      logic [6:0] a;
      int         sr;
      int         sl;
      a = $urandom_range(0, 1) ? 7'h30 : 7'($urandom_range(0, 127));
      if (t % 5 == 4) a = 7'h30 ^ 7'($urandom_range(1, 127));
      sr = 0;
      sl = 0;
      if ($urandom_range(0, 2) == 0) begin
        sr = $urandom_range(2, 9);
        sl = $urandom_range(10, 40);
      end
      start_cmd(a, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), sr, sl);
      finish_cmd(1'b0);
    end

    check_eq("bus_protocol", illegal, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
